painter: RTL and testbench



---
 rtl/painter_pkg.sv | 30 +++
 rtl/runner_pkg.sv | 28 ++
 rtl/sprite_blitter.sv | 113 +++++++++++
 rtl/painter.sv | 181 ++++++++++++++++++
 tb/tb_painter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/painter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : painter_pkg
//  Description : Framebuffer / sprite-sheet geometry, pixel encoding and the
//                painter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package painter_pkg;

    localparam int FB_WIDTH    = 1280;
    localparam int FB_HEIGHT   = 300;
    localparam int SHEET_WIDTH = 2446;

    localparam int ADDR_W      = 19;   // ROM and framebuffer address width
    localparam int COORD_W     = 13;   // signed destination coordinate width

    // Sprite-sheet pixel encoding
    localparam int PIX_OPAQUE  = 1;
    localparam int PIX_COLOUR  = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SLOT  = 3'd2,
        S_DRAW  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/runner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : runner_pkg
//  Description : Render-slot interface types shared between the runner and
//                the painter.
//                sprite_t : sheet x, y, width, height (w==0 or h==0 = empty)
//                pos_t    : destination x, y, two's complement 13-bit
//  Revision    : 1.0  initial release
// ============================================================================
package runner_pkg;

    localparam int RENDER_SLOTS = 32;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] w;
        logic [11:0] h;
    } sprite_t;

    // Coordinates are two's complement; consumers apply $signed as needed.
    typedef struct packed {
        logic [12:0] x;
        logic [12:0] y;
    } pos_t;

endpackage
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter
//  Description : Copies one sheet rectangle to the framebuffer, one pixel per
//                cycle in raster order, with transparency and screen clipping.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_go            pulse: start a rectangle (dx=dy=0)
//                i_rect, i_pos   rectangle and destination, held stable
//                                while busy
//                o_rom_addr      sheet address of the current pixel
//                i_rom_data      pixel for last cycle's o_rom_addr
//                o_fb_we/addr/data  framebuffer write (one cycle behind ROM)
//                o_done          high on the last pixel's address cycle
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_blitter
    import runner_pkg::*;
#(
    parameter int FB_WIDTH    = painter_pkg::FB_WIDTH,
    parameter int FB_HEIGHT   = painter_pkg::FB_HEIGHT,
    parameter int SHEET_WIDTH = painter_pkg::SHEET_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_go,
    input  sprite_t                         i_rect,
    input  pos_t                            i_pos,
    output logic [painter_pkg::ADDR_W-1:0]  o_rom_addr,
    input  logic [1:0]                      i_rom_data,
    output logic                            o_fb_we,
    output logic [painter_pkg::ADDR_W-1:0]  o_fb_addr,
    output logic                            o_fb_data,
    output logic                            o_done
);
    import painter_pkg::*;

    localparam logic [ADDR_W-1:0] c_sheet_pitch = ADDR_W'(SHEET_WIDTH);
    localparam logic [ADDR_W-1:0] c_fb_pitch    = ADDR_W'(FB_WIDTH);
    localparam logic [11:0]       c_fb_w        = 12'(FB_WIDTH);
    localparam logic [11:0]       c_fb_h        = 12'(FB_HEIGHT);

    logic                r_busy;
    logic [11:0]         r_dx;
    logic [11:0]         r_dy;
    logic                r_wv;        // write stage holds a pixel
    logic                r_in;        // that pixel lies on screen
    logic [ADDR_W-1:0]   r_fb_addr;

    logic                w_dx_end;
    logic                w_dy_end;
    logic [ADDR_W-1:0]   w_sx;
    logic [ADDR_W-1:0]   w_sy;
    logic [COORD_W-1:0]  w_x;
    logic [COORD_W-1:0]  w_y;
    logic                w_in;
    logic [ADDR_W-1:0]   w_fb_addr;

    always_comb begin
        w_dx_end  = (r_dx == i_rect.w - 12'd1);
        w_dy_end  = (r_dy == i_rect.h - 12'd1);
        w_sx      = ADDR_W'(i_rect.x) + ADDR_W'(r_dx);
        w_sy      = ADDR_W'(i_rect.y) + ADDR_W'(r_dy);
        // Unsigned 13-bit add equals the signed sum modulo 2^13.
        w_x       = i_pos.x + {1'b0, r_dx};
        w_y       = i_pos.y + {1'b0, r_dy};
        // A clear sign bit makes the low 12 bits the non-negative value.
        w_in      = !w_x[COORD_W-1] && (w_x[11:0] < c_fb_w) &&
                    !w_y[COORD_W-1] && (w_y[11:0] < c_fb_h);
        w_fb_addr = ADDR_W'(w_y[11:0]) * c_fb_pitch + ADDR_W'(w_x[11:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_wv      <= 1'b0;
            r_in      <= 1'b0;
            r_fb_addr <= '0;
        end else begin
            r_wv <= r_busy;
            r_in <= w_in;
            if (r_busy) begin
                r_fb_addr <= w_fb_addr;
            end
            if (i_go) begin
                r_busy <= 1'b1;
                r_dx   <= '0;
                r_dy   <= '0;
            end else if (r_busy) begin
                if (w_dx_end) begin
                    r_dx <= '0;
                    if (w_dy_end) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_dy <= r_dy + 12'd1;
                    end
                end else begin
                    r_dx <= r_dx + 12'd1;
                end
            end
        end
    end

    assign o_rom_addr = r_busy ? (w_sy * c_sheet_pitch + w_sx) : '0;
    assign o_done     = r_busy & w_dx_end & w_dy_end;
    // The ROM pixel arrives now, matching the registered coordinates.
    assign o_fb_we    = r_wv & r_in & i_rom_data[PIX_OPAQUE];
    assign o_fb_addr  = r_fb_addr;
    assign o_fb_data  = r_wv & i_rom_data[PIX_COLOUR];

endmodule
`default_nettype wire

// File: rtl/painter.sv
`default_nettype none
// ============================================================================
//  Module      : painter
//  Description : Render-slot consumer. On start it snapshots every slot,
//                optionally clears the framebuffer, then blits non-empty
//                slots in slot order and raises painter_finished.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                start               pulse, accepted only while idle
//                sprite, pos         per-slot sheet rectangle / destination
//                rom_addr, rom_data  sprite-sheet ROM (1-cycle latency)
//                fb_we/addr/data     framebuffer write port
//                painter_finished    level, frame complete and idle
//  Revision    : 1.0  initial release
// ============================================================================
module painter
    import runner_pkg::*;
#(
    parameter int FB_WIDTH    = painter_pkg::FB_WIDTH,
    parameter int FB_HEIGHT   = painter_pkg::FB_HEIGHT,
    parameter int SHEET_WIDTH = painter_pkg::SHEET_WIDTH,
    parameter int CLEAR_EN    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  sprite_t                         sprite [RENDER_SLOTS],
    input  pos_t                            pos    [RENDER_SLOTS],
    output logic [painter_pkg::ADDR_W-1:0]  rom_addr,
    input  logic [1:0]                      rom_data,
    output logic                            fb_we,
    output logic [painter_pkg::ADDR_W-1:0]  fb_addr,
    output logic                            fb_data,
    output logic                            painter_finished
);
    import painter_pkg::*;

    localparam int                IDX_W        = $clog2(RENDER_SLOTS);
    localparam logic [IDX_W-1:0]  c_last_slot  = IDX_W'(RENDER_SLOTS - 1);
    localparam logic [ADDR_W-1:0] c_clear_last = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    state_t             r_state;
    state_t             w_state_n;
    sprite_t            r_sprite [RENDER_SLOTS];
    pos_t               r_pos    [RENDER_SLOTS];
    logic [IDX_W-1:0]   r_idx;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic               r_finished;

    logic               w_snap;
    logic               w_go;
    logic               w_clearing;
    logic               w_idx_inc;
    logic               w_fin_set;
    logic               w_slot_empty;
    logic               w_blit_done;
    logic               w_blit_we;
    logic               w_blit_data;
    logic [ADDR_W-1:0]  w_blit_addr;

    assign w_slot_empty = (r_sprite[r_idx].w == '0) || (r_sprite[r_idx].h == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // The last slot exits straight to DRAIN so the frame costs exactly
    // one cycle per slot plus one per pixel plus the drain cycle.
    always_comb begin
        w_state_n  = r_state;
        w_snap     = 1'b0;
        w_go       = 1'b0;
        w_clearing = 1'b0;
        w_idx_inc  = 1'b0;
        w_fin_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_snap    = 1'b1;
                    w_state_n = (CLEAR_EN != 0) ? S_CLEAR : S_SLOT;
                end
            end
            S_CLEAR: begin
                w_clearing = 1'b1;
                if (r_clr_addr == c_clear_last) begin
                    w_state_n = S_SLOT;
                end
            end
            S_SLOT: begin
                if (w_slot_empty) begin
                    if (r_idx == c_last_slot) begin
                        w_state_n = S_DRAIN;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end else begin
                    w_go      = 1'b1;
                    w_state_n = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_blit_done) begin
                    if (r_idx == c_last_slot) begin
                        w_state_n = S_DRAIN;
                    end else begin
                        w_idx_inc = 1'b1;
                        w_state_n = S_SLOT;
                    end
                end
            end
            S_DRAIN: begin
                w_fin_set = 1'b1;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Snapshot carries no reset; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (w_snap) begin
            r_sprite <= sprite;
            r_pos    <= pos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_clr_addr <= '0;
            r_finished <= 1'b0;
        end else begin
            if (w_snap) begin
                r_idx      <= '0;
                r_clr_addr <= '0;
                r_finished <= 1'b0;
            end else begin
                if (w_idx_inc) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                if (w_clearing) begin
                    r_clr_addr <= r_clr_addr + ADDR_W'(1);
                end
                if (w_fin_set) begin
                    r_finished <= 1'b1;
                end
            end
        end
    end

    sprite_blitter #(
        .FB_WIDTH    (FB_WIDTH),
        .FB_HEIGHT   (FB_HEIGHT),
        .SHEET_WIDTH (SHEET_WIDTH)
    ) u_blitter (
        .clk        (clk),
        .rst        (rst),
        .i_go       (w_go),
        .i_rect     (r_sprite[r_idx]),
        .i_pos      (r_pos[r_idx]),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_fb_we    (w_blit_we),
        .o_fb_addr  (w_blit_addr),
        .o_fb_data  (w_blit_data),
        .o_done     (w_blit_done)
    );

    // Clearing and blitting never overlap in time.
    assign fb_we            = w_clearing | w_blit_we;
    assign fb_addr          = w_clearing ? r_clr_addr : w_blit_addr;
    assign fb_data          = !w_clearing & w_blit_data;
    assign painter_finished = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_painter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_painter
//  Description : Self-checking bench for painter. A full-size instance with
//                clearing disabled, plus a small-framebuffer instance with
//                clearing enabled. Expected writes and frame latency come
//                from a pixel-loop model of the slot rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_painter;
    import runner_pkg::*;

    localparam int FBW   = 1280;
    localparam int FBH   = 300;
    localparam int SHW   = 2446;
    localparam int CFBW  = 40;
    localparam int CFBH  = 6;
    localparam int BOUND = 20000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    sprite_t     spr_in [RENDER_SLOTS];
    pos_t        pos_in [RENDER_SLOTS];
    sprite_t     spr_m  [RENDER_SLOTS];
    pos_t        pos_m  [RENDER_SLOTS];
    logic [18:0] rom_addr0, rom_addr1, fb_addr0, fb_addr1;
    logic [1:0]  rom_q0, rom_q1;
    logic        fb_we0, fb_we1, fb_data0, fb_data1, fin0, fin1;
    int          rom_mode;
    int          checks;
    int          errors;

    logic [19:0] act_q0 [$];
    logic [19:0] act_q1 [$];
    logic [19:0] exp_q  [$];

    painter #(.CLEAR_EN(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .sprite(spr_in), .pos(pos_in),
        .rom_addr(rom_addr0), .rom_data(rom_q0), .fb_we(fb_we0),
        .fb_addr(fb_addr0), .fb_data(fb_data0), .painter_finished(fin0)
    );

    painter #(.FB_WIDTH(CFBW), .FB_HEIGHT(CFBH), .CLEAR_EN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sprite(spr_in), .pos(pos_in),
        .rom_addr(rom_addr1), .rom_data(rom_q1), .fb_we(fb_we1),
        .fb_addr(fb_addr1), .fb_data(fb_data1), .painter_finished(fin1)
    );

    // Sprite-sheet contents: {opaque, colour} as a function of address.
    function automatic logic [1:0] rom_fn(input logic [18:0] a);
        case (rom_mode)
            0:       return 2'b11;
            1:       return {~a[0], a[1]};
            2:       return {a[0] ^ a[3] ^ a[6], a[1] ^ a[4]};
            default: return {1'b1, (a >= 19'd300000)};
        endcase
    endfunction

    always @(posedge clk) begin
        rom_q0 <= rom_fn(rom_addr0);
        rom_q1 <= rom_fn(rom_addr1);
    end

    always @(negedge clk) begin
        if (fb_we0) act_q0.push_back({fb_addr0, fb_data0});
        if (fb_we1) act_q1.push_back({fb_addr1, fb_data1});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < RENDER_SLOTS; i++) begin
            spr_in[i] = '0;
            pos_in[i] = '0;
        end
    endtask

    task automatic set_slot(input int i, input int sx, input int sy, input int w,
                            input int h, input int px, input int py);
        spr_in[i].x = 12'(sx);
        spr_in[i].y = 12'(sy);
        spr_in[i].w = 12'(w);
        spr_in[i].h = 12'(h);
        pos_in[i].x = 13'(px);
        pos_in[i].y = 13'(py);
    endtask

    // Reference: walk every pixel of every non-empty slot in slot order.
    task automatic build_model(input int fbw, input int fbh, input int clear_n,
                               output int lat);
        int sx, sy, w, h, px, py, x, y, a;
        logic [1:0] pix;
        exp_q.delete();
        for (int c = 0; c < clear_n; c++) exp_q.push_back({19'(c), 1'b0});
        lat = clear_n + RENDER_SLOTS + 1;
        for (int s = 0; s < RENDER_SLOTS; s++) begin
            sx = int'(spr_m[s].x);
            sy = int'(spr_m[s].y);
            w  = int'(spr_m[s].w);
            h  = int'(spr_m[s].h);
            px = int'($signed(pos_m[s].x));
            py = int'($signed(pos_m[s].y));
            if (w != 0 && h != 0) begin
                lat += w * h;
                for (int dy = 0; dy < h; dy++) begin
                    for (int dx = 0; dx < w; dx++) begin
                        x   = px + dx;
                        y   = py + dy;
                        a   = ((sy + dy) * SHW + sx + dx) % 524288;
                        pix = rom_fn(19'(a));
                        if (pix[1] && x >= 0 && x < fbw && y >= 0 && y < fbh)
                            exp_q.push_back({19'(y * fbw + x), pix[0]});
                    end
                end
            end
        end
    endtask

    // Pulse start, scramble live inputs, optionally re-pulse start at cycle
    // 'mid', and count cycles from the start edge until finished rises.
    task automatic run_frame(input int sel, input int mid, output int lat);
        if (sel == 0) act_q0.delete(); else act_q1.delete();
        @(posedge clk); #1;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < RENDER_SLOTS; i++) begin
            spr_in[i] = sprite_t'(48'({$urandom(), $urandom()}));
            pos_in[i] = pos_t'(26'($urandom()));
        end
        check("fin_cleared_on_start", (sel == 0) ? fin0 : fin1, 0);
        lat = 0;
        while (((sel == 0) ? fin0 : fin1) == 1'b0 && lat < BOUND) begin
            @(posedge clk); #1;
            lat++;
            start0 = (sel == 0 && lat == mid);
            start1 = (sel == 1 && lat == mid);
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    function automatic int act_size(input int sel);
        return (sel == 0) ? act_q0.size() : act_q1.size();
    endfunction

    function automatic logic [19:0] act_at(input int sel, input int i);
        return (sel == 0) ? act_q0[i] : act_q1[i];
    endfunction

    task automatic do_frame(input string tag, input int sel, input int mid,
                            input int fbw, input int fbh, input int clear_n);
        int exp_lat, lat, n;
        spr_m = spr_in;
        pos_m = pos_in;
        build_model(fbw, fbh, clear_n, exp_lat);
        run_frame(sel, mid, lat);
        check($sformatf("%s_latency", tag), lat, exp_lat);
        check($sformatf("%s_write_count", tag), act_size(sel), exp_q.size());
        n = (act_size(sel) < exp_q.size()) ? act_size(sel) : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_write%0d", tag, i), 32'(act_at(sel, i)), 32'(exp_q[i]));
    endtask

    initial begin
        logic fbm [int];
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        rom_mode = 0;
        clear_slots();
        repeat (3) @(posedge clk);
        #1;
        check("reset_fin",      fin0,      0);
        check("reset_fb_we",    fb_we0,    0);
        check("reset_fb_addr",  fb_addr0,  0);
        check("reset_fb_data",  fb_data0,  0);
        check("reset_rom_addr", rom_addr0, 0);
        check("reset_fb_we_c",  fb_we1,    0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All slots empty: 33-cycle frame, no writes.
        clear_slots();
        do_frame("empty", 0, -1, FBW, FBH, 0);

        // Single 4x2 opaque sprite.
        clear_slots();
        set_slot(0, 2, 104, 4, 2, 10, 5);
        do_frame("basic", 0, -1, FBW, FBH, 0);
        check("basic_first_addr", 32'(act_q0[0]), 32'({19'd6410, 1'b1}));
        check("basic_last_addr",  32'(act_q0[7]), 32'({19'd7693, 1'b1}));

        // Left-edge and bottom-right clipping.
        clear_slots();
        set_slot(0, 0, 0, 4, 1, -2, 0);
        do_frame("clip_left", 0, -1, FBW, FBH, 0);
        clear_slots();
        set_slot(0, 0, 0, 4, 2, 1278, 299);
        do_frame("clip_br", 0, -1, FBW, FBH, 0);

        // Alternating transparency.
        rom_mode = 1;
        clear_slots();
        set_slot(0, 0, 0, 4, 1, 20, 20);
        do_frame("transp", 0, -1, FBW, FBH, 0);

        // Overlap: slot 11 drawn after slot 3; extra start mid-DRAW ignored.
        rom_mode = 3;
        clear_slots();
        set_slot(3,  0, 10,  3, 2, 50, 50);
        set_slot(11, 0, 150, 3, 2, 50, 50);
        do_frame("overlap", 0, 20, FBW, FBH, 0);
        fbm.delete();
        foreach (act_q0[i]) fbm[int'(act_q0[i][19:1])] = act_q0[i][0];
        check("overlap_final_pixel", fbm[50 * FBW + 50], 1);

        // Randomised frames.
        rom_mode = 2;
        for (int r = 0; r < 4; r++) begin
            clear_slots();
            for (int i = 0; i < RENDER_SLOTS; i++) begin
                if ($urandom_range(0, 3) == 0)
                    set_slot(i, $urandom_range(0, 2400), $urandom_range(0, 200),
                             $urandom_range(1, 5), $urandom_range(1, 5),
                             int'($urandom_range(0, 1291)) - 6,
                             int'($urandom_range(0, 311)) - 6);
                else
                    set_slot(i, $urandom_range(0, 2400), $urandom_range(0, 200),
                             $urandom_range(0, 1) * $urandom_range(1, 5), 0,
                             $urandom_range(0, 1000), $urandom_range(0, 200));
            end
            do_frame($sformatf("rand%0d", r), 0, -1, FBW, FBH, 0);
        end

        // Reset in the middle of a large blit.
        rom_mode = 0;
        clear_slots();
        set_slot(0, 0, 0, 20, 20, 100, 100);
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_draw_we", fb_we0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_fb_we",    fb_we0,    0);
        check("rst_mid_fin",      fin0,      0);
        check("rst_mid_rom_addr", rom_addr0, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_fin_stays_low", fin0, 0);
        clear_slots();
        set_slot(7, 10, 10, 3, 3, 600, 150);
        do_frame("after_reset", 0, -1, FBW, FBH, 0);

        // Clearing instance: full clear precedes the clipped blit.
        clear_slots();
        set_slot(5, 7, 3, 5, 3, 37, 4);
        do_frame("clear", 1, -1, CFBW, CFBH, CFBW * CFBH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
